// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch sequencer: state encoding, default
// debounce settings and the state-to-output decode used by the LED/display logic.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    LAP     = 3'd2,
    STOP    = 3'd3,
    LAPSTOP = 3'd4
  } sw_state_e;

  // 10 ms at 100 MHz
  localparam int unsigned DEB_CYCLES_DEF = 1_000_000;
  localparam int unsigned DEB_W_DEF      = 20;

  typedef struct packed {
    logic cnt_en;
    logic freeze;
  } sw_out_t;

  function automatic sw_out_t state_outputs(sw_state_e s);
    sw_out_t o;
    o.cnt_en = (s == RUN) || (s == LAP);
    o.freeze = (s == LAP) || (s == LAPSTOP);
    return o;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and sequencer outputs between the board buttons and the
// counter/display chain.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic      btn_ss;
  logic      btn_lc;
  logic      cnt_en;
  logic      cnt_clr;
  logic      freeze;
  sw_state_e state;

  modport master (
    output btn_ss, btn_lc,
    input  cnt_en, cnt_clr, freeze, state
  );

  modport slave (
    input  btn_ss, btn_lc,
    output cnt_en, cnt_clr, freeze, state
  );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One push-button: 2-FF synchronizer, stable-count debouncer with an accepted
// level, and a one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned DEB_W      = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [DEB_W-1:0] LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic             press_q;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  // Any sample matching the accepted level restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) level_d = ~level_q;
      else               cnt_d   = cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
      press_q <= level_q & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: two debounced buttons drive a five-state FSM whose
// registered outputs control counting, clearing and display freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned DEB_W      = DEB_W_DEF
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.slave sw
);

  logic      ss_ev, lc_ev;
  sw_state_e state_q, state_d;
  logic      cnt_en_q, cnt_en_d;
  logic      cnt_clr_q, cnt_clr_d;
  logic      freeze_q, freeze_d;
  sw_out_t   out_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_ss (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (sw.btn_ss),
    .press_o (ss_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_lc (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (sw.btn_lc),
    .press_o (lc_ev)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      freeze_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      freeze_q  <= freeze_d;
    end
  end

  // Start/stop takes priority when both buttons fire in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_ev) state_d = RUN;
      RUN:     if (ss_ev) state_d = STOP;    else if (lc_ev) state_d = LAP;
      LAP:     if (ss_ev) state_d = LAPSTOP; else if (lc_ev) state_d = RUN;
      STOP:    if (ss_ev) state_d = RUN;     else if (lc_ev) state_d = IDLE;
      LAPSTOP: if (ss_ev) state_d = LAP;     else if (lc_ev) state_d = STOP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the next state so they change on the same edge as state_q.
  always_comb begin
    out_d     = state_outputs(state_d);
    cnt_en_d  = out_d.cnt_en;
    freeze_d  = out_d.freeze;
    cnt_clr_d = ((state_q == STOP) && (state_d == IDLE)) || (state_q > LAPSTOP);
  end

  assign sw.state   = state_q;
  assign sw.cnt_en  = cnt_en_q;
  assign sw.cnt_clr = cnt_clr_q;
  assign sw.freeze  = freeze_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed button scenarios plus random button
// activity, checked every cycle against a history-based reference model.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int D    = 4;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic reset;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.DEB_CYCLES(D), .DEB_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: raw button samples and accepted levels per edge since reset.
  bit raw_h [2][MAXC];
  bit acc_h [2][MAXC];
  int last_flip [2];
  int n;
  int m_state;
  bit m_clr;
  int ss_next [5] = '{1, 3, 4, 1, 2};
  int lc_next [5] = '{0, 2, 1, 0, 3};
  int clr_cnt, clr_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit accv(int i, int k);
    return (k < 0) ? 1'b0 : acc_h[i][k];
  endfunction

  // Level seen by the debouncer at edge m: the raw sample two edges earlier.
  function automatic bit syncv(int i, int m);
    return (m < 2) ? 1'b0 : raw_h[i][m-2];
  endfunction

  task automatic model_reset();
    n            = 0;
    last_flip[0] = -1;
    last_flip[1] = -1;
    m_state      = 0;
    m_clr        = 1'b0;
  endtask

  task automatic model_edge(input bit ss, input bit lc);
    bit ev [2];
    bit prev, flip;
    if (n >= MAXC) begin
      $display("FAIL model_depth got=%0d limit=%0d", n, MAXC);
      $fatal(1, "model history exhausted");
    end
    raw_h[0][n] = ss;
    raw_h[1][n] = lc;
    for (int i = 0; i < 2; i++) begin
      ev[i] = accv(i, n - 2) && !accv(i, n - 3);
      prev  = accv(i, n - 1);
      // Accept a new level after D consecutive differing samples since the last change.
      flip  = (n - last_flip[i]) >= D;
      for (int m = n - D + 1; m <= n; m++)
        if (m >= 0 && syncv(i, m) == prev) flip = 1'b0;
      acc_h[i][n] = flip ? !prev : prev;
      if (flip) last_flip[i] = n;
    end
    m_clr = 1'b0;
    if (ev[0]) m_state = ss_next[m_state];
    else if (ev[1]) begin
      m_clr   = (m_state == 3);
      m_state = lc_next[m_state];
    end
    n++;
  endtask

  // Drive at a negedge, let one posedge happen, compare, return at the next negedge.
  task automatic cycle(input bit ss, input bit lc);
    sw_if.btn_ss = ss;
    sw_if.btn_lc = lc;
    @(posedge clk);
    model_edge(ss, lc);
    #1;
    chk("state",   32'(sw_if.state),   32'(m_state));
    chk("cnt_en",  32'(sw_if.cnt_en),  32'(m_state == 1 || m_state == 2));
    chk("freeze",  32'(sw_if.freeze),  32'(m_state == 2 || m_state == 4));
    chk("cnt_clr", 32'(sw_if.cnt_clr), 32'(m_clr));
    if (sw_if.cnt_clr) begin
      clr_cnt++;
      if (sw_if.state != IDLE || sw_if.cnt_en) clr_bad++;
    end
    @(negedge clk);
  endtask

  task automatic press(input bit ss, input bit lc);
    for (int k = 0; k < 9; k++) cycle(ss, lc);
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_state",   32'(sw_if.state),   32'(0));
    chk("rst_cnt_en",  32'(sw_if.cnt_en),  32'(0));
    chk("rst_freeze",  32'(sw_if.freeze),  32'(0));
    chk("rst_cnt_clr", 32'(sw_if.cnt_clr), 32'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  bit rs, rl;

  initial begin
    reset        = 1'b1;
    sw_if.btn_ss = 1'b0;
    sw_if.btn_lc = 1'b0;
    clr_cnt      = 0;
    clr_bad      = 0;
    @(negedge clk);
    do_reset();

    // Short press shorter than the debounce window
    for (int k = 0; k < 3; k++)  cycle(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0);
    chk("bounce_state", 32'(sw_if.state),  32'(0));
    chk("bounce_en",    32'(sw_if.cnt_en), 32'(0));

    // Held start/stop: cnt_en rises on the 7th edge after the input edge
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0);
      chk("en_latency", 32'(sw_if.cnt_en), 32'(k >= 7));
    end
    chk("run_state",  32'(sw_if.state),  32'(1));
    chk("run_freeze", 32'(sw_if.freeze), 32'(0));
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0);

    press(1'b0, 1'b1);
    chk("lap_state",  32'(sw_if.state),  32'(2));
    chk("lap_en",     32'(sw_if.cnt_en), 32'(1));
    chk("lap_freeze", 32'(sw_if.freeze), 32'(1));
    press(1'b1, 1'b0);
    chk("lapstop_state",  32'(sw_if.state),  32'(4));
    chk("lapstop_en",     32'(sw_if.cnt_en), 32'(0));
    chk("lapstop_freeze", 32'(sw_if.freeze), 32'(1));
    press(1'b0, 1'b1);
    chk("stop_state",  32'(sw_if.state),  32'(3));
    chk("stop_en",     32'(sw_if.cnt_en), 32'(0));
    chk("stop_freeze", 32'(sw_if.freeze), 32'(0));

    // Clear from STOP, then a second lap/clear in IDLE
    clr_cnt = 0;
    clr_bad = 0;
    press(1'b0, 1'b1);
    chk("clear_state", 32'(sw_if.state), 32'(0));
    chk("clr_once",    32'(clr_cnt),     32'(1));
    chk("clr_in_idle", 32'(clr_bad),     32'(0));
    clr_cnt = 0;
    press(1'b0, 1'b1);
    chk("clr_again",   32'(clr_cnt),     32'(0));
    chk("idle_lc",     32'(sw_if.state), 32'(0));

    // Both buttons together from RUN: start/stop wins
    press(1'b1, 1'b0);
    chk("rerun_state", 32'(sw_if.state), 32'(1));
    press(1'b1, 1'b1);
    chk("both_state",  32'(sw_if.state), 32'(3));

    // Reset while in LAP with lap/clear held through release
    press(1'b1, 1'b0);
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1);
    chk("held_lap_state", 32'(sw_if.state), 32'(2));
    do_reset();
    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b1);
    chk("post_rst_state", 32'(sw_if.state), 32'(0));
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0);

    // Random button activity with occasional resets
    for (int seg = 0; seg < 6; seg++) begin
      rs = 1'b0;
      rl = 1'b0;
      do_reset();
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 7) == 0) rs = !rs;
        if ($urandom_range(0, 7) == 0) rl = !rl;
        cycle(rs, rl);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-driven sequencer for the stopwatch datapath. Debounces two push-buttons (start/stop and lap/clear) and runs a five-state FSM that drives the count-enable, the one-cycle clear, and the display freeze for the tick generators, second counters and stopwatch latches. It sits between the board buttons and the counter/display chain in the stopwatch top level, replacing the raw `freeze` switch.

## Interface
Parameters:
- `DEB_CYCLES`, 1_000_000: consecutive stable cycles required to accept a new button level (10 ms at 100 MHz); minimum 1.
- `DEB_W`, 20: width of the debounce counter; must satisfy 2^DEB_W > DEB_CYCLES.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_ss`  in  1  start/stop button, active-high, asynchronous to `clk`.
- `btn_lc`  in  1  lap/clear button, active-high, asynchronous to `clk`.
- `cnt_en`  out  1  count enable to the tick generators and second counters.
- `cnt_clr`  out  1  one-cycle synchronous clear pulse to the counters.
- `freeze`  out  1  display hold to the stopwatch latches (1 = hold last value).
- `state`  out  3  current FSM encoding, for LEDs and debug.

## Operation
- Each button goes through a 2-FF synchronizer and then a debouncer. The debouncer holds an accepted level (reset 0) and a counter. When the synchronized input differs from the accepted level, the counter increments; otherwise it is cleared. When the count reaches DEB_CYCLES, the accepted level flips and the counter clears.
- A press event is a one-cycle pulse on an accepted 0→1 transition. Releases generate no event.
- Simultaneous `ss` and `lc` events in the same cycle: `ss` wins and `lc` is discarded.
- FSM states, with `(cnt_en, freeze)` for each:
  - IDLE=0 (0,0)
  - RUN=1 (1,0)
  - LAP=2 (1,1)
  - STOP=3 (0,0)
  - LAPSTOP=4 (0,1)
- Transitions (`ss` = start/stop event, `lc` = lap/clear event):
  - IDLE: ss→RUN; lc→IDLE (no effect).
  - RUN: ss→STOP; lc→LAP.
  - LAP: ss→LAPSTOP; lc→RUN (release the lap; display jumps to live time).
  - STOP: ss→RUN (resume, no clear); lc→IDLE and assert `cnt_clr` for exactly one cycle.
  - LAPSTOP: ss→LAP (resume counting, display still held); lc→STOP (show the stopped time).
- Encodings 5–7 are illegal and return to IDLE on the next edge, with `cnt_clr` pulsed.
- All outputs are registered, decoded from the next state, and glitch-free.

## Timing
- Reset (`reset`=0, async) sets: FSM to IDLE, `cnt_en`=0, `cnt_clr`=0, `freeze`=0, `state`=0, debounce counters=0, accepted levels=0, synchronizers=0.
- Reset asserted mid-operation (any state, any debounce count) takes effect immediately. A button held through reset release must be re-accepted, which takes the full DEB_CYCLES; it then produces one press event.
- Latency: a button is stable-high from edge t. The press pulse is high in cycle t+2+DEB_CYCLES. The FSM and outputs update at edge t+3+DEB_CYCLES.
- A bounce (input returns to the accepted level) before the count reaches DEB_CYCLES clears the counter and produces no event.
- `cnt_clr` is high in the same cycle that `state` first reads IDLE and `cnt_en` reads 0.
- Holding a button produces exactly one event. A second event needs a release (accepted 0) followed by a new press.

## Structure
- Shared package `stopwatch_pkg`: the state enum (IDLE, RUN, LAP, STOP, LAPSTOP) with the encodings above, and the default DEB_CYCLES constant, for reuse by the display/LED decoding.
- Sub-module `btn_debounce` (synchronizer, debounce counter, accepted level, press pulse), parameterized by DEB_CYCLES/DEB_W and instantiated twice.
- The FSM and output registers live in `stopwatch_ctrl`.

## Test plan
All scenarios use DEB_CYCLES=4.
- Reset, then hold `btn_ss` high → `cnt_en` rises exactly 7 cycles after the input edge; `state`=1; `freeze`=0.
- Pulse `btn_ss` high for 3 cycles, then low (bounce) → no event; `state` stays 0 and `cnt_en` stays 0.
- Sequence ss, lc, ss, lc → states 1, 2, 4, 3. `(cnt_en, freeze)` follows (1,0), (1,1), (0,1), (0,0).
- From STOP press lc → `state`=0; `cnt_clr` high for exactly 1 cycle, coincident with `state`=0; a further lc gives no pulse.
- Press both buttons in the same cycle from RUN → `state`=3 (STOP); the lap is ignored.
- Assert `reset` low while in LAP with `btn_lc` held → outputs go to 0 immediately. After release, one lc event is accepted after 4+2 cycles; `state` stays 0 because lc in IDLE is ignored.
